// File: rtl/spacewar_disp_pkg.sv
// Shared geometry, address widths and the frame-arbiter state encoding
// for the display path.
package spacewar_disp_pkg;
    localparam int COLS    = 80;
    localparam int ROWS    = 24;
    localparam int FB_BITS = 1920;
    localparam int X_W     = 7;
    localparam int Y_W     = 5;
    localparam int ADDR_W  = 11;

    typedef enum logic [1:0] {ST_CLEAR, ST_DRAW, ST_SWAP} disp_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr with wrap,
// returns a one-hot grant and the pointer just past the winner.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   next_ptr
);
    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PW'((int'(idx) + 1) % NREQ);
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_arbiter.sv
// Double-buffered cell display: requesters draw into a private back buffer,
// a vsync falling edge copies it to the front buffer, then the back is cleared.
module frame_arbiter #(
    parameter int NREQ = 4,
    parameter int COLS = spacewar_disp_pkg::COLS,
    parameter int ROWS = spacewar_disp_pkg::ROWS
) (
    input  logic                                    clk_50,
    input  logic                                    rst,
    input  logic                                    vsync,
    input  logic [NREQ-1:0]                         req,
    input  logic [NREQ*spacewar_disp_pkg::X_W-1:0]  wr_x,
    input  logic [NREQ*spacewar_disp_pkg::Y_W-1:0]  wr_y,
    input  logic [NREQ-1:0]                         wr_val,
    output logic [NREQ-1:0]                         gnt,
    output logic [COLS*ROWS-1:0]                    game_display,
    output logic                                    frame_start,
    output logic                                    busy,
    output logic                                    overrun,
    output logic                                    drop
);
    import spacewar_disp_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    disp_state_t           state;
    logic [COLS*ROWS-1:0]  back;
    logic [Y_W-1:0]        row;
    logic [PW-1:0]         ptr;
    logic                  vs_s1, vs_s2, vs_d;
    logic                  swapped;
    logic                  swap_evt;

    logic [NREQ-1:0]       grant;
    logic [PW-1:0]         next_ptr;
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic                  sel_val;
    logic                  in_range;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W-1:0]     row_base;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // vs_d holds the previous synchronised sample so a high->low step is one cycle wide
    assign swap_evt = vs_d & ~vs_s2;
    assign busy     = (state != ST_DRAW);

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_val = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_x   = sel_x | wr_x[X_W*i +: X_W];
                sel_y   = sel_y | wr_y[Y_W*i +: Y_W];
                sel_val = sel_val | wr_val[i];
            end
        end
    end

    assign in_range = (int'(sel_x) < COLS) && (int'(sel_y) < ROWS);
    assign addr     = ADDR_W'(sel_y) * ADDR_W'(COLS) + ADDR_W'(sel_x);
    assign row_base = ADDR_W'(row) * ADDR_W'(COLS);

    always_ff @(posedge clk_50) begin
        if (rst) begin
            vs_s1        <= 1'b1;
            vs_s2        <= 1'b1;
            vs_d         <= 1'b1;
            state        <= ST_CLEAR;
            row          <= '0;
            ptr          <= '0;
            gnt          <= '0;
            game_display <= '0;
            frame_start  <= 1'b0;
            swapped      <= 1'b0;
            overrun      <= 1'b0;
            drop         <= 1'b0;
        end else begin
            vs_s1       <= vsync;
            vs_s2       <= vs_s1;
            vs_d        <= vs_s2;
            gnt         <= '0;
            swapped     <= 1'b0;
            frame_start <= swapped;
            case (state)
                ST_CLEAR: begin
                    back[row_base +: COLS] <= '0;
                    if (swap_evt) overrun <= 1'b1;
                    if (int'(row) == ROWS - 1) begin
                        row   <= '0;
                        state <= ST_DRAW;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                ST_DRAW: begin
                    if (swap_evt) begin
                        state <= ST_SWAP;
                    end else if (|req) begin
                        gnt <= grant;
                        ptr <= next_ptr;
                        if (in_range) back[addr] <= sel_val;
                        else          drop       <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    game_display <= back;
                    swapped      <= 1'b1;
                    state        <= ST_CLEAR;
                    if (swap_evt) overrun <= 1'b1;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_arbiter.sv
// Self-checking bench for frame_arbiter: randomized requesters against a
// cell-level buffer model, plus directed swap, overrun and reset scenarios.
module tb_frame_arbiter;
    localparam int NREQ = 4;
    localparam int COLS = 80;
    localparam int ROWS = 24;
    localparam int FB   = COLS * ROWS;

    logic                clk_50 = 1'b0;
    logic                rst, vsync;
    logic [NREQ-1:0]     req, wr_val, gnt;
    logic [NREQ*7-1:0]   wr_x;
    logic [NREQ*5-1:0]   wr_y;
    logic [FB-1:0]       game_display;
    logic                frame_start, busy, overrun, drop;

    int vectors     = 0;
    int miscompares = 0;

    logic [FB-1:0] m_back, m_disp;
    int            m_ptr;
    logic          m_drop, m_overrun;

    always #10 clk_50 = ~clk_50;

    frame_arbiter #(.NREQ(NREQ), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk_50       (clk_50),
        .rst          (rst),
        .vsync        (vsync),
        .req          (req),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_val       (wr_val),
        .gnt          (gnt),
        .game_display (game_display),
        .frame_start  (frame_start),
        .busy         (busy),
        .overrun      (overrun),
        .drop         (drop)
    );

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Lowest index at or after p (cyclically) that is requesting, or -1.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        logic [NREQ-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic set_data(input int i, input int x, input int y, input int v);
        wr_x[7*i +: 7] = 7'(x);
        wr_y[5*i +: 5] = 5'(y);
        wr_val[i]      = v[0];
    endtask

    task automatic model_grant(input int i);
        int x, y;
        x = int'(wr_x[7*i +: 7]);
        y = int'(wr_y[5*i +: 5]);
        m_ptr = (i + 1) % NREQ;
        if (x < COLS && y < ROWS) m_back[y*COLS + x] = wr_val[i];
        else                      m_drop = 1'b1;
    endtask

    task automatic model_reset();
        m_back = '0; m_disp = '0; m_ptr = 0; m_drop = 1'b0; m_overrun = 1'b0;
    endtask

    // Single-requester write with the req/gnt handshake.
    task automatic do_write(input int i, input int x, input int y, input int v);
        set_data(i, x, y, v);
        req[i] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt !== '0) break;
        end
        vectors++;
        if (gnt !== onehot(i)) begin
            miscompares++;
            $display("FAIL write_gnt[%0d]: got %b expected %b", i, gnt, onehot(i));
        end else begin
            model_grant(i);
        end
        req[i] = 1'b0;
    endtask

    task automatic wait_draw(input string tag);
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 60) begin
            tick();
            c++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", tag, busy, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vsync = 1'b1; req = '0; wr_x = '0; wr_y = '0; wr_val = '0;
        model_reset();
        repeat (3) tick();
        vectors++;
        if ({gnt, frame_start, overrun, drop} !== '0 || game_display !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: gnt=%b fs=%b ovr=%b drop=%b busy=%b disp_ones=%0d expected 0/0/0/0/1/0",
                     gnt, frame_start, overrun, drop, busy, $countones(game_display));
        end
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            vectors++;
            if (busy !== (k < 24) || gnt !== '0) begin
                miscompares++;
                $display("FAIL reset_clear[%0d]: busy=%b gnt=%b expected busy=%b gnt=0", k, busy, gnt, k < 24);
            end
        end
        vectors++;
        if (game_display !== '0) begin
            miscompares++;
            $display("FAIL reset_disp: %0d bits set, expected 0", $countones(game_display));
        end
    endtask

    task automatic test_round_robin();
        int idx;
        for (int i = 0; i < NREQ; i++)
            set_data(i, $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), $urandom_range(0, 1));
        req = '1;
        for (int c = 0; c < 5; c++) begin
            tick();
            idx = rr_pick(req, m_ptr);
            vectors++;
            if (gnt !== onehot(idx)) begin
                miscompares++;
                $display("FAIL rr_seq[%0d]: got %b expected %b", c, gnt, onehot(idx));
            end
            model_grant(idx);
        end
        req = '0;
        vectors++;
        if (drop !== m_drop) begin
            miscompares++;
            $display("FAIL rr_drop: got %b expected %b", drop, m_drop);
        end
    endtask

    task automatic test_random_draw();
        int idx;
        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_data(i, $urandom_range(0, 84), $urandom_range(0, 25), $urandom_range(0, 1));
                    req[i] = 1'b1;
                end
            tick();
            idx = rr_pick(req, m_ptr);
            vectors++;
            if (gnt !== onehot(idx)) begin
                miscompares++;
                $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, onehot(idx));
            end
            if (idx >= 0) begin
                model_grant(idx);
                req[idx] = 1'b0;
            end
            vectors++;
            if (drop !== m_drop) begin
                miscompares++;
                $display("FAIL rand_drop[%0d]: got %b expected %b", c, drop, m_drop);
            end
        end
        req = '0;
    endtask

    task automatic test_swap();
        logic [FB-1:0] old_disp;
        int first_change, fs_count, fs_edge;
        logic busy_seen;
        do_write(1, 0, 1, 0);
        do_write(2, 79, 23, 1);
        do_write(0, 80, 0, 1);
        vectors++;
        if (drop !== 1'b1) begin
            miscompares++;
            $display("FAIL swap_drop: got %b expected 1", drop);
        end
        old_disp = game_display;
        first_change = -1; fs_count = 0; fs_edge = -1; busy_seen = 1'b0;
        vsync = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 4) vsync = 1'b1;
            if (first_change < 0 && game_display !== old_disp) first_change = e;
            if (frame_start === 1'b1) begin fs_count++; fs_edge = e; end
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        m_disp = m_back;
        m_back = '0;
        vectors++;
        if (first_change < 1 || first_change > 5) begin
            miscompares++;
            $display("FAIL swap_latency: display changed at edge %0d, expected 1..5", first_change);
        end
        vectors++;
        if (game_display !== m_disp) begin
            miscompares++;
            $display("FAIL swap_disp: %0d bits differ from model", $countones(game_display ^ m_disp));
        end
        vectors++;
        if (game_display[1919] !== 1'b1 || game_display[80] !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_cells: bit1919=%b bit80=%b expected 1 and 0", game_display[1919], game_display[80]);
        end
        vectors++;
        if (fs_count != 1 || fs_edge != first_change + 1) begin
            miscompares++;
            $display("FAIL swap_frame_start: %0d pulses at edge %0d, expected 1 at edge %0d",
                     fs_count, fs_edge, first_change + 1);
        end
        vectors++;
        if (!busy_seen || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL swap_busy: busy_seen=%b overrun=%b expected 1 and 0", busy_seen, overrun);
        end
        wait_draw("swap");
    endtask

    task automatic test_overrun();
        do_write(3, 10, 10, 1);
        vsync = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        m_disp = m_back;
        m_back = '0;
        vectors++;
        if (game_display !== m_disp) begin
            miscompares++;
            $display("FAIL ovr_first_swap: %0d bits differ from model", $countones(game_display ^ m_disp));
        end
        repeat (3) tick();
        vsync = 1'b0;
        repeat (4) tick();
        vsync = 1'b1;
        m_overrun = 1'b1;
        wait_draw("ovr");
        repeat (6) tick();
        vectors++;
        if (overrun !== m_overrun) begin
            miscompares++;
            $display("FAIL ovr_flag: got %b expected %b", overrun, m_overrun);
        end
        vectors++;
        if (game_display !== m_disp || game_display[10*COLS + 10] !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_disp: %0d bits differ, cell(10,10)=%b expected 1",
                     $countones(game_display ^ m_disp), game_display[10*COLS + 10]);
        end
    endtask

    task automatic test_swap_priority();
        int idx, c;
        logic last_busy;
        vsync = 1'b0;
        repeat (2) tick();
        set_data(1, 5, 5, 1);
        req[1] = 1'b1;
        tick();
        vectors++;
        if (gnt !== '0) begin
            miscompares++;
            $display("FAIL prio_gnt: got %b expected 0000 on swap cycle", gnt);
        end
        vsync = 1'b1;
        m_disp = m_back;
        m_back = '0;
        last_busy = busy;
        c = 0;
        while (gnt === '0 && c < 60) begin
            last_busy = busy;
            tick();
            c++;
        end
        idx = rr_pick(req, m_ptr);
        vectors++;
        if (gnt !== onehot(idx) || last_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_late_gnt: got %b (busy before=%b) expected %b after CLEAR",
                     gnt, last_busy, onehot(idx));
        end
        if (idx >= 0) model_grant(idx);
        req = '0;
        vectors++;
        if (game_display !== m_disp) begin
            miscompares++;
            $display("FAIL prio_disp: %0d bits differ from model", $countones(game_display ^ m_disp));
        end
    endtask

    task automatic test_reset_mid();
        int idx;
        for (int i = 0; i < NREQ; i++)
            set_data(i, $urandom_range(0, COLS-1), $urandom_range(0, ROWS-1), 1);
        req = '1;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({gnt, frame_start, overrun, drop} !== '0 || game_display !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_state: gnt=%b fs=%b ovr=%b drop=%b busy=%b disp_ones=%0d expected 0/0/0/0/1/0",
                     gnt, frame_start, overrun, drop, busy, $countones(game_display));
        end
        rst = 1'b0;
        model_reset();
        for (int k = 1; k <= 24; k++) begin
            tick();
            vectors++;
            if (gnt !== '0 || busy !== (k < 24)) begin
                miscompares++;
                $display("FAIL midrst_clear[%0d]: gnt=%b busy=%b expected 0 and %b", k, gnt, busy, k < 24);
            end
        end
        tick();
        idx = rr_pick(req, m_ptr);
        vectors++;
        if (gnt !== onehot(idx) || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_first_gnt: got %b expected %b", gnt, onehot(idx));
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_random_draw();
        test_swap();
        test_overrun();
        test_swap_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
        $fatal(1);
    end
endmodule
